// File: rtl/jtag_scan_master_if.sv
// Command/response channel between the host logic and jtag_scan_master.
// The host drives the master side; the scan sequencer sits on the slave side.
interface jtag_scan_master_if #(
  parameter int MAX_LEN = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [5:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_scan_master.sv
// Host-side JTAG sequencer: walks the TAP with TMS headers/trailers,
// shifts up to MAX_LEN bits LSB-first and returns captured TDO.
module jtag_scan_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtag_scan_master_if.slave    bus,
  output logic                 busy,
  output logic                 tck,
  output logic                 tms,
  output logic                 tdi,
  input  logic                 tdo
);

  localparam int SW = $clog2(2 * CLK_DIV);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [SW-1:0] HALF = SW'(CLK_DIV);
  localparam logic [SW-1:0] LAST = SW'(2 * CLK_DIV - 1);
  localparam logic [6:0]    MAXL = 7'(MAX_LEN);

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SHIFT,
    S_TRL,
    S_RSP
  } state_t;

  state_t state_q, state_d;

  logic               live_q;
  logic [SW-1:0]      stp_q;
  logic [5:0]         bit_q;
  logic [1:0]         op_q;
  logic [5:0]         len_q;
  logic [MAX_LEN-1:0] dat_q;
  logic [MAX_LEN-1:0] cap_q;
  logic               err_q;
  logic               tms_q;

  logic       accept;
  logic       illegal;
  logic       active;
  logic       step_end;
  logic       phase_end;
  logic       scan;
  logic [7:0] hdr_pat;
  logic [5:0] hdr_last;

  assign bus.cmd_ready = (state_q == S_IDLE) && live_q;
  assign bus.rsp_valid = (state_q == S_RSP);
  assign bus.rsp_data  = cap_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != S_IDLE);

  assign accept  = bus.cmd_valid && bus.cmd_ready;
  assign illegal = (bus.cmd_op != OP_RST) &&
                   ((bus.cmd_len == 6'd0) ||
                    ({1'b0, bus.cmd_len} > MAXL));

  assign active   = (state_q == S_HDR) ||
                    (state_q == S_SHIFT) ||
                    (state_q == S_TRL);
  assign step_end = active && (stp_q == LAST);
  assign scan     = (op_q == OP_IR) || (op_q == OP_DR);

  assign tck = active && (stp_q >= HALF);
  assign tdi = (state_q == S_SHIFT) && scan &&
               dat_q[bit_q[IW-1:0]];

  // Header TMS patterns, bit i is driven on header step i.
  always_comb begin
    hdr_pat  = 8'h00;
    hdr_last = 6'd0;
    unique case (op_q)
      OP_RST: begin
        hdr_pat  = 8'b0001_1111;
        hdr_last = 6'd5;
      end
      OP_IR: begin
        hdr_pat  = 8'b0000_0011;
        hdr_last = 6'd3;
      end
      OP_DR: begin
        hdr_pat  = 8'b0000_0001;
        hdr_last = 6'd2;
      end
      default: begin
        hdr_pat  = 8'h00;
        hdr_last = 6'd0;
      end
    endcase
  end

  always_comb begin
    phase_end = 1'b0;
    unique case (state_q)
      S_HDR:   phase_end = (bit_q == hdr_last);
      S_SHIFT: phase_end = (bit_q == len_q - 6'd1);
      S_TRL:   phase_end = (bit_q == 6'd1);
      default: phase_end = 1'b0;
    endcase
  end

  // tms_q remembers the last driven value so it holds between commands.
  always_comb begin
    tms = tms_q;
    unique case (state_q)
      S_HDR:   tms = hdr_pat[bit_q[2:0]];
      S_SHIFT: tms = scan && phase_end;
      S_TRL:   tms = (bit_q == 6'd0);
      default: tms = tms_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            illegal:
              state_d = S_RSP;
            !illegal && (bus.cmd_op == OP_IDLE):
              state_d = S_SHIFT;
            !illegal && (bus.cmd_op != OP_IDLE):
              state_d = S_HDR;
            default:
              state_d = S_IDLE;
          endcase
        end
      end
      S_HDR: begin
        if (step_end && phase_end)
          state_d = (op_q == OP_RST) ? S_RSP : S_SHIFT;
      end
      S_SHIFT: begin
        if (step_end && phase_end)
          state_d = scan ? S_TRL : S_RSP;
      end
      S_TRL: begin
        if (step_end && phase_end)
          state_d = S_RSP;
      end
      S_RSP: begin
        if (bus.rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q <= 1'b0;
      stp_q  <= '0;
      bit_q  <= 6'd0;
      op_q   <= OP_RST;
      len_q  <= 6'd0;
      dat_q  <= '0;
      cap_q  <= '0;
      err_q  <= 1'b0;
      tms_q  <= 1'b1;
    end else begin
      live_q <= 1'b1;
      if (active) tms_q <= tms;
      if (accept) begin
        op_q  <= bus.cmd_op;
        len_q <= bus.cmd_len;
        dat_q <= bus.cmd_data;
        cap_q <= '0;
        err_q <= illegal;
        stp_q <= '0;
        bit_q <= 6'd0;
      end else if (active) begin
        stp_q <= step_end ? '0 : stp_q + 1'b1;
        if (step_end)
          bit_q <= phase_end ? 6'd0 : bit_q + 6'd1;
        // TDO is sampled on the final clk of the high phase.
        if ((state_q == S_SHIFT) && scan && (stp_q == LAST))
          cap_q[bit_q[IW-1:0]] <= tdo;
      end
    end
  end

endmodule

// File: doc/jtag_scan_master.md
# jtag_scan_master

Host-side JTAG sequencer that drives the TCK/TMS/TDI pins of a downstream TAP controller and captures TDO. It accepts one scan command at a time over a valid/ready interface: TAP reset, IR scan, DR scan or idle clocking. It walks the TAP state machine with the correct TMS sequence, shifts up to 32 bits LSB-first, and returns the captured TDO word over a valid/ready response channel. It sits between the debug/host bus logic and the chip's `jtag_tap` pins, and is the only driver of those pins.

## Interface
- `CLK_DIV`, default 4: TCK half-period in `clk` cycles. Minimum is 2.
- `MAX_LEN`, default 32: maximum shift length in bits, and the width of the data paths.

Ports:
- `clk`  in  1  system clock. The only clock; TCK is derived from it.
- `rst_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  command type: 00 RESET, 01 IR_SCAN, 10 DR_SCAN, 11 IDLE.
- `cmd_len`  in  6  bit count (scans) or TCK count (IDLE); legal range 1..MAX_LEN.
- `cmd_data`  in  MAX_LEN  TDI bits; bit 0 is shifted first.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_data`  out  MAX_LEN  captured TDO, right-aligned; unused upper bits are 0.
- `rsp_err`  out  1  command was illegal; no TCK activity occurred.
- `busy`  out  1  a command is in progress or a response is pending.
- `tck`  out  1  JTAG test clock.
- `tms`  out  1  JTAG mode select.
- `tdi`  out  1  JTAG data to the TAP.
- `tdo`  in  1  JTAG data from the TAP. Sampled directly; TCK is slow relative to `clk`.

## Operation
- **FSM states:** IDLE, HDR (TMS header), SHIFT, TRL (TMS trailer), RSP.
  - IDLE: on accept, go to HDR, or to RSP if the command is illegal.
  - HDR, SHIFT and TRL run in that order. Ops with an empty phase skip it.
  - TRL goes to RSP.
  - RSP goes to IDLE on the response handshake.
- **Step:** one TCK period, 2×CLK_DIV `clk` cycles.
  - `tck` is low for the first CLK_DIV cycles and high for the last CLK_DIV.
  - `tms` and `tdi` update on the first cycle of each step, i.e. at TCK fall.
  - `tdo` is sampled on the last `clk` cycle of the high phase.
- **RESET:** 6 steps, TMS = 1,1,1,1,1,0. The TAP ends in Run-Test/Idle. No SHIFT phase; `rsp_data` = 0.
- **IR_SCAN:** starts from Run-Test/Idle.
  - HDR: TMS = 1,1,0,0 (to Shift-IR).
  - SHIFT: `cmd_len` steps, with TMS = 0 on every step except TMS = 1 on the last (to Exit1).
  - TRL: TMS = 1,0 (Update, then Run-Test/Idle).
- **DR_SCAN:** same as IR_SCAN with HDR TMS = 1,0,0.
- **IDLE:** `cmd_len` steps with TMS = 0. `tdi` = 0 and TDO is not captured.
- **TDI/TDO mapping:** during SHIFT step i, `tdi` = `cmd_data[i]`, and the sampled `tdo` goes to `rsp_data[i]`.
- **`tdi` outside SHIFT:** 0.
- **Illegal command:** `cmd_len` of 0 or greater than MAX_LEN, for any op except RESET. It produces no steps, `rsp_err` = 1 and `rsp_data` = 0. RESET ignores `cmd_len`.
- **Pin state across commands:** after any command `tck` = 0, and `tms` holds its last value (0 after every legal op).
- **After `rst_n`:** the TAP state is undefined. The host must issue RESET first; the block does not check this.
- **Counters:** step counter log2(2×CLK_DIV) bits; bit counter 6 bits, counting from 0 to `cmd_len`−1 with no wrap.

## Timing
- **Reset values (cycle after `rst_n` low):**
  - `tck` = 0, `tms` = 1, `tdi` = 0.
  - `cmd_ready` = 0 during reset, 1 in the first cycle after `rst_n` rises.
  - `rsp_valid` = 0, `rsp_err` = 0, `rsp_data` = 0, `busy` = 0.
- **Command accept:** `cmd_ready` = 1 only in IDLE. Command fields are registered on accept, and `cmd_ready` drops the next cycle.
- **First step:** begins the cycle after accept.
- **Latency, legal command:** accept to `rsp_valid` = N×2×CLK_DIV + 1 cycles, where N is the total step count.
- **Latency, illegal command:** `rsp_valid` is asserted 1 cycle after accept.
- **Response hold:** `rsp_valid`, `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
- **Back-to-back:** `cmd_ready` returns to 1 the cycle after the response handshake. If `rsp_ready` is high when `rsp_valid` rises, the handshake completes in that cycle.
- **`busy`:** 1 from the cycle after accept until the cycle after the response handshake.
- **Reset mid-command:** all outputs return to reset values at the next `clk` edge. The command is discarded and no response is produced.
- **`cmd_valid` while busy:** ignored. No accept, and no effect on the running sequence.

## Test plan
- **RESET:** `rst_n` pulse, then RESET with CLK_DIV=4 -> exactly 6 TCK pulses; TMS=1,1,1,1,1,0 sampled at TCK rise; `rsp_valid` 49 cycles after accept with `rsp_data`=0 and `rsp_err`=0.
- **IR scan:** IR_SCAN len=4, data=4'b1010 into a `jtag_tap` model -> 10 TCK pulses; TDI during shift = 0,1,0,1; TMS 1 on the 4th shift bit; instruction register = 4'b1010; TAP ends in Run-Test/Idle.
- **DR loopback:** DR_SCAN len=8, data=8'hA5, with TDO modelled as TDI delayed one TCK -> 13 TCK pulses; `rsp_data`=32'h0000004A, i.e. bits shifted by one with bit0 = the initial TDO value of 0.
- **Illegal length:** DR_SCAN len=0, then IDLE len=33 -> no TCK edges; each sets `rsp_err`=1 one cycle after accept; next RESET runs normally.
- **Backpressure:** hold `rsp_ready`=0 for 20 cycles after `rsp_valid` -> response stable and `cmd_ready`=0 throughout; a `cmd_valid` pulse in this window is not accepted.
- **Reset mid-scan:** `rst_n` low during the 3rd shift bit of a DR_SCAN len=16 -> next edge gives `tck`=0, `tms`=1, `rsp_valid`=0; after release `cmd_ready`=1 and no stale response appears.
